// File: rtl/sys1_inp_pkg.sv
// sys1_inp_pkg: shared constants for the System 1 input conditioner.
// Joy bit positions, coin FSM encoding, debounce counter width and the
// port-mapping helpers used by the output stage.
package sys1_inp_pkg;

   // Raw joystick bit positions (same map for both players)
   localparam int JB_R  = 0;
   localparam int JB_L  = 1;
   localparam int JB_D  = 2;
   localparam int JB_U  = 3;
   localparam int JB_F1 = 4;
   localparam int JB_F2 = 5;
   localparam int JB_F3 = 6;
   localparam int JB_F4 = 7;
   localparam int JB_F5 = 8;
   localparam int JB_S1 = 9;
   localparam int JB_S2 = 10;
   localparam int JB_CO = 11;

   localparam int NJ   = 12;
   localparam int DB_W = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_REL = 2'd2
   } coin_st_t;

   // Player port byte (active-low); wm selects the twin-stick layout
   function automatic logic [7:0] map_player(input logic [NJ-1:0] d, input logic wm);
      logic [7:0] r;
      if (wm)
         r = {d[JB_L], d[JB_R], d[JB_U], d[JB_D], d[JB_F2], d[JB_F1], d[JB_F4], d[JB_F3]};
      else
         r = {d[JB_L], d[JB_R], d[JB_U], d[JB_D], 1'b0, d[JB_F2], d[JB_F1], d[JB_F3]};
      return ~r;
   endfunction

   // System port byte (active-low): starts, coin, and the twin-stick triggers
   function automatic logic [7:0] map_system(input logic [NJ-1:0] d1, input logic [NJ-1:0] d2,
                                             input logic wm, input logic coin);
      logic s1;
      logic s2;
      s1 = d1[JB_S1];
      s2 = d1[JB_S2] | d2[JB_S1];
      return ~{wm & d2[JB_F5], wm & d1[JB_F5], s2, s1, 3'b000, coin};
   endfunction

endpackage

// File: rtl/sys1_debounce.sv
// sys1_debounce: one joystick bit, 2-flop synchroniser followed by a
// counter debouncer. Build macro SYS1_INP_DEBOUNCE_EN enables the counter;
// without it the stable value is the synchronised value directly.
// sync_o exposes the synchronised (undebounced) level.
module sys1_debounce
   import sys1_inp_pkg::*;
#(
   parameter int DB_CYCLES = 48000
) (
   input  logic clk_sys,
   input  logic reset_n,
   input  logic raw_i,
   output logic sync_o,
   output logic stable_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage synchroniser into clk_sys
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

`ifdef SYS1_INP_DEBOUNCE_EN
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            stable_q, stable_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // Count consecutive disagreeing cycles; adopt the new level after DB_CYCLES of them
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync_q != stable_q) begin
         if (cnt_q == DB_LAST)
            stable_d = sync_q;
         else
            cnt_d = cnt_q + DB_W'(1);
      end
   end

   // Debounce state registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;
`else
   localparam int DB_CYCLES_UNUSED = DB_CYCLES;
   assign stable_o = sync_q;
`endif

endmodule

// File: rtl/sys1_input_conditioner.sv
// sys1_input_conditioner: synchronises/debounces both players' controls,
// stretches coin presses into frame-counted pulses and drives the three
// active-low System 1 input ports. Build macro SYS1_INP_DEBOUNCE_EN
// enables per-bit debouncing (see sys1_debounce).
// coin_st_o exposes the coin FSM state for observation.
module sys1_input_conditioner
   import sys1_inp_pkg::*;
#(
   parameter int DB_CYCLES   = 48000,
   parameter int COIN_FRAMES = 3
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic [11:0] joy1,
   input  logic [11:0] joy2,
   input  logic        vblank,
   input  logic        water_match,
   output logic [7:0]  INP0,
   output logic [7:0]  INP1,
   output logic [7:0]  INP2,
   output logic [1:0]  coin_st_o
);

   localparam int FC_W = $clog2(COIN_FRAMES + 1);

   logic [2*NJ-1:0] raw;
   logic [2*NJ-1:0] syn;
   logic [2*NJ-1:0] deb;

   assign raw = {joy2, joy1};

   for (genvar g = 0; g < 2 * NJ; g++) begin : g_bit
      sys1_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
         .clk_sys  (clk_sys),
         .reset_n  (reset_n),
         .raw_i    (raw[g]),
         .sync_o   (syn[g]),
         .stable_o (deb[g])
      );
   end

   // Only the coin bits of the raw synchronised view are needed, and player 2's S2 is unmapped
   logic sync_unused;
   assign sync_unused = ^{syn, deb[NJ + JB_S2]};

   // ---------------------------------------------------------------- coin
   coin_st_t        st_q, st_d;
   logic [FC_W-1:0] fc_q, fc_d;
   logic            vb_prev_q;
   logic            coin_prev_q;
   logic            armed_q, armed_d;
   logic [1:0]      settle_q, settle_d;
   logic            coin_src, coin_sync, vb_rise, coin_rise, coin_out;

   assign coin_src  = deb[JB_CO] | deb[NJ + JB_CO];
   assign coin_sync = syn[JB_CO] | syn[NJ + JB_CO];
   assign vb_rise   = vblank & ~vb_prev_q;
   // Edges only count once the coin line has been seen released after reset,
   // so a coin held through reset cannot fire on the post-reset debounce ramp.
   assign coin_rise = coin_src & ~coin_prev_q & armed_q;
   assign coin_out  = (st_q == PULSE);
   assign coin_st_o = st_q;

   // Coin FSM next state, frame counter and release arming
   always_comb begin
      st_d     = st_q;
      fc_d     = fc_q;
      settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      armed_d  = armed_q | ((settle_q == 2'd3) & ~coin_sync);
      case (st_q)
         IDLE: begin
            if (coin_rise) begin
               st_d = PULSE;
               fc_d = FC_W'(COIN_FRAMES);
            end
         end
         PULSE: begin
            if (vb_rise) begin
               fc_d = fc_q - FC_W'(1);
               if (fc_q == FC_W'(1))
                  st_d = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!coin_src)
               st_d = IDLE;
         end
         default: st_d = IDLE;
      endcase
   end

   // Coin FSM and edge-detect registers
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         st_q        <= IDLE;
         fc_q        <= '0;
         vb_prev_q   <= 1'b0;
         coin_prev_q <= 1'b0;
         armed_q     <= 1'b0;
         settle_q    <= '0;
      end else begin
         st_q        <= st_d;
         fc_q        <= fc_d;
         vb_prev_q   <= vblank;
         coin_prev_q <= coin_src;
         armed_q     <= armed_d;
         settle_q    <= settle_d;
      end
   end

   // ---------------------------------------------------------------- ports
   logic [7:0] inp0_q, inp0_d;
   logic [7:0] inp1_q, inp1_d;
   logic [7:0] inp2_q, inp2_d;

   // Port mapping; water_match is applied live, no flush on change
   always_comb begin
      inp0_d = map_player(deb[NJ-1:0], water_match);
      inp1_d = map_player(deb[2*NJ-1:NJ], water_match);
      inp2_d = map_system(deb[NJ-1:0], deb[2*NJ-1:NJ], water_match, coin_out);
   end

   // Output registers, idle high
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         inp0_q <= 8'hFF;
         inp1_q <= 8'hFF;
         inp2_q <= 8'hFF;
      end else begin
         inp0_q <= inp0_d;
         inp1_q <= inp1_d;
         inp2_q <= inp2_d;
      end
   end

   assign INP0 = inp0_q;
   assign INP1 = inp1_q;
   assign INP2 = inp2_q;

endmodule

// File: tb/tb_sys1_input_conditioner.sv
// tb_sys1_input_conditioner: directed vectors against a behavioural model
// of the input conditioner, plus hand-computed literal expectations.
// Works with or without SYS1_INP_DEBOUNCE_EN defined.
module tb_sys1_input_conditioner;

   localparam int DB = 16;
   localparam int CF = 3;
`ifdef SYS1_INP_DEBOUNCE_EN
   localparam bit DB_EN = 1'b1;
`else
   localparam bit DB_EN = 1'b0;
`endif
   localparam int LAT = DB_EN ? (DB + 3) : 3;

   // ---------------------------------------------------------- clock/reset
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic [11:0] joy1 = '0;
   logic [11:0] joy2 = '0;
   logic        vblank = 1'b0;
   logic        water_match = 1'b0;
   logic [7:0]  INP0, INP1, INP2;
   logic [1:0]  coin_st;

   always #5 clk_sys = ~clk_sys;

   sys1_input_conditioner #(.DB_CYCLES(DB), .COIN_FRAMES(CF)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .joy1        (joy1),
      .joy2        (joy2),
      .vblank      (vblank),
      .water_match (water_match),
      .INP0        (INP0),
      .INP1        (INP1),
      .INP2        (INP2),
      .coin_st_o   (coin_st)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkint(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------- model
   // Debounced level of each bit = synced level once it has disagreed with
   // the held level for DB consecutive samples; synced = raw two edges ago.
   logic [23:0] hist[$];
   logic [23:0] stab;
   int          run[24];
   bit          m_pulse, m_wait, m_armed, m_prev_src, m_vb_prev;
   int          m_left, m_edges;
   logic [7:0]  e0 = 8'hFF, e1 = 8'hFF, e2 = 8'hFF;

   function automatic logic [7:0] pmap(input logic [11:0] d, input bit wm);
      int src[8];
      logic [7:0] r;
      // source joy bit for output bits 0..7, -1 = constant 0
      if (wm) src = '{6, 7, 4, 5, 2, 3, 0, 1};
      else    src = '{6, 4, 5, -1, 2, 3, 0, 1};
      for (int i = 0; i < 8; i++) r[i] = (src[i] < 0) ? 1'b0 : d[src[i]];
      return ~r;
   endfunction

   function automatic logic [7:0] smap(input logic [11:0] d1, input logic [11:0] d2,
                                       input bit wm, input bit coin);
      logic [7:0] r;
      r    = '0;
      r[0] = coin;
      r[4] = d1[9];
      r[5] = d1[10] | d2[9];
      r[6] = wm & d1[8];
      r[7] = wm & d2[8];
      return ~r;
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      stab = '0;
      for (int b = 0; b < 24; b++) run[b] = 0;
      m_pulse = 0; m_wait = 0; m_armed = 0; m_prev_src = 0; m_vb_prev = 0;
      m_left = 0; m_edges = 0;
      e0 = 8'hFF; e1 = 8'hFF; e2 = 8'hFF;
   endtask

   task automatic model_step();
      logic [23:0] syn, d;
      bit src, vb_rise, rise;
      syn = hist[0];
      d   = DB_EN ? stab : syn;
      src = d[11] | d[23];
      vb_rise = vblank && !m_vb_prev;
      e0 = pmap(d[11:0], water_match);
      e1 = pmap(d[23:12], water_match);
      e2 = smap(d[11:0], d[23:12], water_match, m_pulse);
      m_edges++;
      rise = src && !m_prev_src && m_armed;
      if (m_pulse) begin
         if (vb_rise) begin
            m_left--;
            if (m_left == 0) begin m_pulse = 0; m_wait = 1; end
         end
      end else if (m_wait) begin
         if (!src) m_wait = 0;
      end else if (rise) begin
         m_pulse = 1;
         m_left  = CF;
      end
      m_prev_src = src;
      if (m_edges >= 4 && !(syn[11] | syn[23])) m_armed = 1;
      m_vb_prev = vblank;
      for (int b = 0; b < 24; b++) begin
         if (syn[b] != stab[b]) run[b]++;
         else run[b] = 0;
         if (run[b] == DB) begin stab[b] = syn[b]; run[b] = 0; end
      end
      void'(hist.pop_front());
      hist.push_back({joy2, joy1});
   endtask

   always @(posedge clk_sys) begin
      if (!reset_n) model_reset();
      else model_step();
   end

   // ---------------------------------------------------------- scoreboard
   always @(posedge clk_sys) begin
      #1;
      check8("model_inp0", INP0, e0);
      check8("model_inp1", INP1, e1);
      check8("model_inp2", INP2, e2);
   end

   // ---------------------------------------------------------- driver
   bit vb_run = 0;
   int vb_cnt = 0;
   bit mon_vb_prev = 0;
   bit mon_c0 = 1;
   int pulse_vb = 0;
   int coin_falls = 0;

   // One clock: monitor at edge+1, then advance vblank
   task automatic cyc();
      @(posedge clk_sys);
      #1;
      if (vblank && !mon_vb_prev && !INP2[0]) pulse_vb++;
      mon_vb_prev = vblank;
      if (mon_c0 && !INP2[0]) coin_falls++;
      mon_c0 = INP2[0];
      if (vb_run) begin
         vb_cnt++;
         vblank = (vb_cnt % 24) >= 20;
      end
   endtask

   initial begin
      int n;
      bit seen;

      // reset with everything pressed
      joy1 = '1; joy2 = '1; water_match = 0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         check8("rst_inp0", INP0, 8'hFF);
         check8("rst_inp1", INP1, 8'hFF);
         check8("rst_inp2", INP2, 8'hFF);
      end
      reset_n = 1;
      n = 0;
      while (INP0 == 8'hFF && n < 200) begin cyc(); n++; end
      checkint("rst_release_latency", n, LAT);
      check8("all_on_inp0", INP0, 8'h08);
      check8("all_on_inp1", INP1, 8'h08);
      repeat (30) cyc();
      check8("all_on_inp2", INP2, 8'hCF);
      checkint("held_coin_no_pulse", coin_falls, 0);

      joy1 = '0; joy2 = '0;
      repeat (LAT + 3) cyc();
      check8("idle_inp0", INP0, 8'hFF);
      check8("idle_inp2", INP2, 8'hFF);

      // glitch on UP shorter than the debounce window
      joy1[3] = 1'b1;
      repeat (10) cyc();
      joy1[3] = 1'b0;
      seen = 0;
      for (int i = 0; i < LAT + 5; i++) begin
         cyc();
         if (INP0 != 8'hFF) seen = 1;
      end
      checkint("glitch_reaches_port", int'(seen), DB_EN ? 0 : 1);

      // held UP
      joy1[3] = 1'b1;
      n = 0;
      while (INP0 != 8'hDF && n < 100) begin cyc(); n++; end
      checkint("press_latency", n, LAT);
      check8("up_inp0", INP0, 8'hDF);
      joy1 = '0;
      repeat (LAT + 3) cyc();

      // mapping vectors
      water_match = 1; joy1 = 12'h020;
      repeat (LAT + 1) cyc();
      check8("wm_f2_inp0", INP0, 8'hF7);
      water_match = 0;
      cyc();
      check8("std_f2_inp0", INP0, 8'hFB);
      joy1 = 12'h0C0;
      repeat (LAT + 1) cyc();
      check8("std_f3f4_inp0", INP0, 8'hFE);
      water_match = 1;
      cyc();
      check8("wm_f3f4_inp0", INP0, 8'hFC);
      joy1 = '0; joy2 = 12'h300;
      repeat (LAT + 1) cyc();
      check8("wm_trig_inp2", INP2, 8'h5F);
      check8("wm_trig_inp1", INP1, 8'hFF);
      water_match = 0;
      cyc();
      check8("std_trig_inp2", INP2, 8'hDF);
      joy2 = '0;
      repeat (LAT + 3) cyc();

      // coin held for 10 frames
      vb_run = 1;
      pulse_vb = 0; coin_falls = 0;
      joy2[11] = 1'b1;
      repeat (240) cyc();
      joy2[11] = 1'b0;
      repeat (LAT + 30) cyc();
      checkint("coin_pulse_frames", pulse_vb, CF);
      checkint("coin_single_pulse", coin_falls, 1);
      joy2[11] = 1'b1;
      repeat (150) cyc();
      joy2[11] = 1'b0;
      repeat (LAT + 30) cyc();
      checkint("coin_repress_pulses", coin_falls, 2);
      checkint("coin_repress_frames", pulse_vb, 2 * CF);

      // reset mid-pulse with the coin held through release
      joy1[11] = 1'b1;
      n = 0;
      while (INP2[0] && n < 200) begin cyc(); n++; end
      checkint("coin_pulse_before_reset", int'(INP2[0]), 0);
      #2;
      reset_n = 0;
      #1;
      check8("mid_reset_inp2", INP2, 8'hFF);
      cyc();
      cyc();
      reset_n = 1;
      coin_falls = 0;
      repeat (240) cyc();
      checkint("held_after_reset_no_pulse", coin_falls, 0);
      joy1[11] = 1'b0;
      repeat (LAT + 30) cyc();
      joy1[11] = 1'b1;
      repeat (150) cyc();
      joy1[11] = 1'b0;
      repeat (LAT + 10) cyc();
      checkint("coin_after_release_pulse", coin_falls, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // bounded run time
   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
